// File: rtl/dbg_pkg.sv
// ============================================================================
// Module : dbg_pkg
// Brief  : Shared types for the fetch-trace debug blocks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dbg_pkg;

  localparam int PC_W_DEF   = 64;
  localparam int INST_W_DEF = 32;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    FROZEN  = 2'd1,
    DUMP    = 2'd2
  } dbg_state_e;

  typedef struct packed {
    logic [PC_W_DEF-1:0]   pc;
    logic [INST_W_DEF-1:0] inst;
  } fetch_rec_t;

endpackage

`default_nettype wire

// File: rtl/dbg_trace_ring.sv
// ============================================================================
// Module : dbg_trace_ring
// Brief  : DEPTH x REC_W register-file ring with write pointer, saturating
//          occupancy, clear and an asynchronous read port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dbg_trace_ring #(
  parameter int DEPTH = 16,
  parameter int REC_W = 96,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [REC_W-1:0] wr_data,
  input  logic             clear,
  input  logic [AW-1:0]    rd_addr,
  output logic [REC_W-1:0] rd_data,
  output logic [AW-1:0]    wptr,
  output logic [AW:0]      occupancy
);

  localparam logic [AW:0] c_full = (AW+1)'(DEPTH);

  logic [REC_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW:0]      r_occ;

  // Storage needs no reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_occ  <= '0;
    end else begin
      if (wr_en) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (clear) begin
        r_occ <= '0;
      end else if (wr_en && (r_occ != c_full)) begin
        r_occ <= r_occ + (AW+1)'(1);
      end
    end
  end

  assign rd_data   = r_mem[rd_addr];
  assign wptr      = r_wptr;
  assign occupancy = r_occ;

endmodule

`default_nettype wire

// File: rtl/dbg_fetch_trace.sv
// ============================================================================
// Module : dbg_fetch_trace
// Brief  : Fetch-stage tracer: PC-filtered capture ring, fetch counter, stall
//          alarm and oldest-first replay over a valid/ready dump port.
//          Define DBG_FETCH_TRACE_DISPLAY_EN for simulation trace printing.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dbg_fetch_trace #(
  parameter int PC_W        = 64,
  parameter int INST_W      = 32,
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 32,
  parameter int STALL_LIMIT = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_valid,
  input  logic [PC_W-1:0]        fetch_pc,
  input  logic [INST_W-1:0]      fetch_inst,
  input  logic [PC_W-1:0]        filter_lo,
  input  logic [PC_W-1:0]        filter_hi,
  input  logic                   freeze,
  input  logic                   dump_req,
  output logic                   dump_valid,
  output logic [PC_W-1:0]        dump_pc,
  output logic [INST_W-1:0]      dump_inst,
  output logic                   dump_last,
  input  logic                   dump_ready,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [CNT_W-1:0]       fetch_count,
  output logic                   stall_alarm
);

  import dbg_pkg::*;

  localparam int AW    = $clog2(DEPTH);
  localparam int OW    = AW + 1;
  localparam int REC_W = PC_W + INST_W;
  localparam int SW    = $clog2(STALL_LIMIT + 1);
  localparam logic [SW-1:0] c_stall_limit = SW'(STALL_LIMIT);

  dbg_state_e r_state, w_state_next;

  logic              w_hit, w_wr_en, w_clear, w_enter, w_handshake, w_advance;
  logic [AW-1:0]     w_wptr, w_start, w_rd_addr, r_rptr;
  logic [OW-1:0]     w_occ, r_beat;
  logic [REC_W-1:0]  w_rd_data;
  logic [PC_W-1:0]   w_rd_pc, r_dump_pc;
  logic [INST_W-1:0] w_rd_inst, r_dump_inst;
  logic              r_dump_last;
  logic [CNT_W-1:0]  r_fetch_count;
  logic [SW-1:0]     r_stall_cnt, w_stall_next;
  logic              r_alarm, w_alarm_next;

  // An inverted window (lo > hi) can never satisfy both bounds.
  assign w_hit       = fetch_valid && (fetch_pc >= filter_lo) && (fetch_pc <= filter_hi);
  assign w_wr_en     = w_hit && (r_state == CAPTURE);
  assign w_handshake = (r_state == DUMP) && dump_ready;
  assign w_clear     = w_handshake && r_dump_last;
  assign w_advance   = w_handshake && !r_dump_last;
  assign w_enter     = (r_state == FROZEN) && freeze && dump_req && (w_occ != '0);
  assign w_start     = w_wptr - w_occ[AW-1:0];
  assign w_rd_addr   = (r_state == DUMP) ? (r_rptr + AW'(1)) : w_start;
  assign {w_rd_pc, w_rd_inst} = w_rd_data;

  dbg_trace_ring #(
    .DEPTH (DEPTH),
    .REC_W (REC_W)
  ) u_ring (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (w_wr_en),
    .wr_data   ({fetch_pc, fetch_inst}),
    .clear     (w_clear),
    .rd_addr   (w_rd_addr),
    .rd_data   (w_rd_data),
    .wptr      (w_wptr),
    .occupancy (w_occ)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      CAPTURE: if (freeze) w_state_next = FROZEN;
      FROZEN: begin
        if (!freeze)     w_state_next = CAPTURE;
        else if (w_enter) w_state_next = DUMP;
      end
      DUMP:    if (w_clear) w_state_next = FROZEN;
      default: w_state_next = CAPTURE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= CAPTURE;
    else        r_state <= w_state_next;
  end

  // Replay data is prefetched one beat ahead so it is registered at the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr      <= '0;
      r_beat      <= '0;
      r_dump_pc   <= '0;
      r_dump_inst <= '0;
      r_dump_last <= 1'b0;
    end else if (w_enter) begin
      r_rptr      <= w_start;
      r_beat      <= OW'(1);
      r_dump_pc   <= w_rd_pc;
      r_dump_inst <= w_rd_inst;
      r_dump_last <= (w_occ == OW'(1));
    end else if (w_advance) begin
      r_rptr      <= r_rptr + AW'(1);
      r_beat      <= r_beat + OW'(1);
      r_dump_pc   <= w_rd_pc;
      r_dump_inst <= w_rd_inst;
      r_dump_last <= ((r_beat + OW'(1)) == w_occ);
    end else if (w_clear) begin
      r_dump_last <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= '0;
    end else if (w_wr_en && (r_fetch_count != '1)) begin
      r_fetch_count <= r_fetch_count + CNT_W'(1);
    end
  end

  always_comb begin
    w_stall_next = r_stall_cnt;
    if (fetch_valid)                       w_stall_next = '0;
    else if (r_stall_cnt != c_stall_limit) w_stall_next = r_stall_cnt + SW'(1);
  end

  assign w_alarm_next = (w_stall_next == c_stall_limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_alarm     <= 1'b0;
    end else begin
      r_stall_cnt <= w_stall_next;
      r_alarm     <= w_alarm_next;
    end
  end

  assign dump_valid  = (r_state == DUMP);
  assign dump_pc     = r_dump_pc;
  assign dump_inst   = r_dump_inst;
  assign dump_last   = r_dump_last;
  assign occupancy   = w_occ;
  assign fetch_count = r_fetch_count;
  assign stall_alarm = r_alarm;

`ifdef DBG_FETCH_TRACE_DISPLAY_EN
  // CHECK_ENV normally comes from isa.vh; print unconditionally without it.
`ifndef CHECK_ENV
`define CHECK_ENV(name) 1'b1
`endif
  always_ff @(posedge clk) begin
    if (rst_n && `CHECK_ENV("VERBOSE")) begin
      if (w_wr_en)
        $display("%0t Fetch: [%h] %h", $time, fetch_pc, fetch_inst);
      if (w_handshake)
        $display("%0t Dump[%0d]: [%h] %h", $time, r_beat - OW'(1), r_dump_pc, r_dump_inst);
      if (w_alarm_next && !r_alarm)
        $display("%0t Fetch stall", $time);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dbg_fetch_trace.sv
// ============================================================================
// Module : tb_dbg_fetch_trace
// Brief  : Directed bench with a dump-port scoreboard for dbg_fetch_trace.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dbg_fetch_trace;

  localparam int PC_W        = 64;
  localparam int INST_W      = 32;
  localparam int DEPTH       = 16;
  localparam int CNT_W       = 32;
  localparam int STALL_LIMIT = 1024;
  localparam int OW          = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fetch_valid;
  logic [PC_W-1:0]   fetch_pc;
  logic [INST_W-1:0] fetch_inst;
  logic [PC_W-1:0]   filter_lo, filter_hi;
  logic              freeze, dump_req, dump_ready;
  logic              dump_valid, dump_last, stall_alarm;
  logic [PC_W-1:0]   dump_pc;
  logic [INST_W-1:0] dump_inst;
  logic [OW-1:0]     occupancy;
  logic [CNT_W-1:0]  fetch_count;

  always #5 clk = ~clk;

  dbg_fetch_trace #(
    .PC_W (PC_W), .INST_W (INST_W), .DEPTH (DEPTH),
    .CNT_W (CNT_W), .STALL_LIMIT (STALL_LIMIT)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .fetch_valid (fetch_valid), .fetch_pc (fetch_pc), .fetch_inst (fetch_inst),
    .filter_lo (filter_lo), .filter_hi (filter_hi),
    .freeze (freeze), .dump_req (dump_req),
    .dump_valid (dump_valid), .dump_pc (dump_pc), .dump_inst (dump_inst),
    .dump_last (dump_last), .dump_ready (dump_ready),
    .occupancy (occupancy), .fetch_count (fetch_count), .stall_alarm (stall_alarm)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic fail_bound(input string name);
    n_total++;
    $display("FAIL %s: bound expired, %0d beats still expected", name, exp_q.size());
  endtask

  function automatic logic [31:0] inst_of(input logic [63:0] pc);
    return pc[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [63:0] pc);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    fetch_inst  = inst_of(pc);
    tick();
    fetch_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [63:0] pc, input logic last);
    exp_t e;
    e.pc   = pc;
    e.inst = inst_of(pc);
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int target);
    int n = 0;
    while (exp_q.size() > target && n < 200) begin
      tick();
      n++;
    end
    if (exp_q.size() > target) fail_bound(name);
  endtask

  // Monitor: pops the scoreboard on each handshake, checks stability under back-pressure.
  exp_t        mon_e;
  logic        hold = 1'b0;
  logic [63:0] held_pc;
  logic        held_last;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && dump_valid === 1'b1) begin
      if (hold) begin
        check("stall_pc_stable", dump_pc, held_pc);
        check("stall_last_stable", 64'(dump_last), 64'(held_last));
      end
      if (dump_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL dump_unexpected: got beat pc 0x%0h, required no beat", dump_pc);
        end else begin
          mon_e = exp_q.pop_front();
          check("dump_pc", dump_pc, mon_e.pc);
          check("dump_inst", 64'(dump_inst), 64'(mon_e.inst));
          check("dump_last", 64'(dump_last), 64'(mon_e.last));
        end
        hold = 1'b0;
      end else begin
        hold      = 1'b1;
        held_pc   = dump_pc;
        held_last = dump_last;
      end
    end else begin
      hold = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; fetch_valid = 1'b0; fetch_pc = '0; fetch_inst = '0;
    filter_lo = 64'h8000_0000; filter_hi = 64'h8000_FFFF;
    freeze = 1'b0; dump_req = 1'b0; dump_ready = 1'b0;
    repeat (3) tick();
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_fetch_count", 64'(fetch_count), 64'd0);
    check("rst_dump_valid", 64'(dump_valid), 64'd0);
    check("rst_stall_alarm", 64'(stall_alarm), 64'd0);
    rst_n = 1'b1;
    tick();

    // Filter window: boundary PCs both sides, 5 hits, 3 misses.
    fetch(64'h8000_0000); fetch(64'h8000_0004); fetch(64'h7FFF_FFFC);
    fetch(64'h8000_FFFF); fetch(64'h8001_0000); fetch(64'h8000_0008);
    fetch(64'h0000_0000); fetch(64'h8000_0010);
    check("filter_occupancy", 64'(occupancy), 64'd5);
    check("filter_fetch_count", 64'(fetch_count), 64'd5);

    freeze = 1'b1;
    tick();
    push_exp(64'h8000_0000, 1'b0); push_exp(64'h8000_0004, 1'b0);
    push_exp(64'h8000_FFFF, 1'b0); push_exp(64'h8000_0008, 1'b0);
    push_exp(64'h8000_0010, 1'b1);
    dump_ready = 1'b1; dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    wait_drain("drain_small", 0);
    check("small_done_valid", 64'(dump_valid), 64'd0);
    check("small_done_occupancy", 64'(occupancy), 64'd0);

    // Wrap: 20 hits into 16 entries, last hit coincides with freeze.
    freeze = 1'b0;
    tick();
    for (int k = 0; k < 19; k++) fetch(64'h8000_0000 + 64'(4 * k));
    freeze = 1'b1;
    fetch(64'h8000_0000 + 64'(4 * 19));
    check("wrap_occupancy", 64'(occupancy), 64'd16);
    check("wrap_fetch_count", 64'(fetch_count), 64'd25);
    for (int j = 0; j < 16; j++) push_exp(64'h8000_0010 + 64'(4 * j), (j == 15));
    dump_ready = 1'b1; dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    tick();
    dump_ready = 1'b0;
    repeat (3) tick();
    check("backpressure_valid", 64'(dump_valid), 64'd1);
    check("backpressure_pc", dump_pc, 64'h8000_0014);
    dump_ready = 1'b1;
    wait_drain("drain_wrap", 0);
    check("wrap_done_valid", 64'(dump_valid), 64'd0);
    check("wrap_done_occupancy", 64'(occupancy), 64'd0);

    // Empty and frozen: dump_req ignored, fetches not captured.
    dump_req = 1'b1;
    repeat (3) tick();
    dump_req = 1'b0;
    check("empty_dump_valid", 64'(dump_valid), 64'd0);
    fetch(64'h8000_0020);
    check("frozen_occupancy", 64'(occupancy), 64'd0);
    check("frozen_fetch_count", 64'(fetch_count), 64'd25);

    // Reset in the middle of a dump, on beat 5 of 16.
    freeze = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) fetch(64'h8000_0010 + 64'(4 * k));
    check("refill_fetch_count", 64'(fetch_count), 64'd41);
    freeze = 1'b1;
    tick();
    for (int j = 0; j < 16; j++) push_exp(64'h8000_0010 + 64'(4 * j), (j == 15));
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    wait_drain("drain_to_beat5", 12);
    check("beat5_pc", dump_pc, 64'h8000_0020);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dump_valid", 64'(dump_valid), 64'd0);
    check("async_rst_occupancy", 64'(occupancy), 64'd0);
    check("async_rst_fetch_count", 64'(fetch_count), 64'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1; freeze = 1'b0; dump_ready = 1'b0;
    tick();
    fetch(64'h8000_0100);
    check("resume_occupancy", 64'(occupancy), 64'd1);
    check("resume_fetch_count", 64'(fetch_count), 64'd1);

    // Inverted window captures nothing.
    filter_lo = 64'h9000_0000; filter_hi = 64'h8000_0000;
    fetch(64'h8800_0000);
    check("inverted_occupancy", 64'(occupancy), 64'd1);
    filter_lo = 64'h8000_0000; filter_hi = 64'h8000_FFFF;

    // Stall alarm at exactly STALL_LIMIT idle cycles.
    fetch(64'h0);
    repeat (STALL_LIMIT - 1) tick();
    check("stall_before_limit", 64'(stall_alarm), 64'd0);
    tick();
    check("stall_at_limit", 64'(stall_alarm), 64'd1);
    repeat (5) tick();
    check("stall_held", 64'(stall_alarm), 64'd1);
    fetch(64'h0);
    check("stall_cleared", 64'(stall_alarm), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dbg_fetch_trace.md
Name: dbg_fetch_trace

Overview:
- Parametrised fetch-stage debug tracer, successor to the per-cycle fetch print monitor.
- Captures filtered (pc, inst) fetch events into a DEPTH-entry ring buffer and counts fetches.
- Raises a stall alarm when fetch goes idle too long.
- On freeze, holds the history and replays it oldest-first over a valid/ready dump port for the debug unit or testbench.
- Sits beside the fetch stage; purely observational, never back-pressures fetch.

Parameters:
- PC_W, 64, fetch PC width
- INST_W, 32, instruction width
- DEPTH, 16, ring-buffer entries; power of two, >= 2
- CNT_W, 32, fetch counter width
- STALL_LIMIT, 1024, idle cycles before stall_alarm; >= 1

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- fetch_valid  in  1  fetch event this cycle
- fetch_pc  in  PC_W  fetch PC
- fetch_inst  in  INST_W  fetched instruction
- filter_lo  in  PC_W  inclusive lower PC bound for capture
- filter_hi  in  PC_W  inclusive upper PC bound for capture
- freeze  in  1  stop capture (level, sampled per cycle)
- dump_req  in  1  start replay; honoured only while frozen
- dump_valid  out  1  replay beat valid
- dump_pc  out  PC_W  replay PC
- dump_inst  out  INST_W  replay instruction
- dump_last  out  1  final beat of replay
- dump_ready  in  1  consumer accepts beat
- occupancy  out  $clog2(DEPTH)+1  valid entries held
- fetch_count  out  CNT_W  accepted (filtered) fetches
- stall_alarm  out  1  no fetch_valid for STALL_LIMIT cycles

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk. All state updates on posedge clk.
- Reset values: all outputs 0, state CAPTURE, write pointer 0, stall counter 0. Reset mid-dump aborts the dump immediately.
- Hit condition: fetch_valid && filter_lo <= fetch_pc <= fetch_pc <= filter_hi, unsigned compare. If filter_lo > filter_hi, nothing is captured.
- States:
  - CAPTURE:
    - A hit writes {pc, inst} at wptr; wptr wraps modulo DEPTH.
    - occupancy increments, saturating at DEPTH. When full, the oldest entry is overwritten.
    - fetch_count increments, saturating at all-ones.
    - freeze=1 -> FROZEN. A hit in the same cycle as freeze is still captured.
  - FROZEN:
    - No capture; counters hold.
    - freeze=0 -> CAPTURE with buffer contents kept.
    - dump_req=1 && occupancy>0 -> DUMP, read pointer = (wptr - occupancy) mod DEPTH.
    - dump_req with occupancy 0 is ignored.
    - If freeze=0 and dump_req=1 arrive together, freeze=0 wins.
  - DUMP:
    - dump_valid=1 with registered dump_pc/dump_inst at the read pointer.
    - A beat completes when dump_valid && dump_ready.
    - dump_last=1 on beat number occupancy.
    - Data and dump_last stay stable while dump_ready=0.
    - After the last beat: dump_valid=0 next cycle, state -> FROZEN, occupancy -> 0 (buffer drained).
    - freeze and dump_req are ignored in DUMP.
- Latency: capture visible in occupancy 1 cycle after the hit. First dump beat valid 1 cycle after dump_req is accepted.
- Stall counter:
  - Counts cycles with fetch_valid=0 in every state; fetch_valid=1 clears it to 0. Filter does not apply.
  - stall_alarm=1 (registered) when counter == STALL_LIMIT; the counter saturates there.
  - Alarm clears the cycle after a fetch_valid.

Optional Feature:
- Macro DBG_FETCH_TRACE_DISPLAY_EN.
- When defined: on every captured hit, $display of $time, "Fetch: [pc] inst". On each dump beat handshake, "Dump[i]: [pc] inst". One "Fetch stall" message on the rising edge of stall_alarm. Printing is gated by CHECK_ENV("VERBOSE") from isa.vh.
- When undefined: no simulation-only code; ports and behaviour are identical.

Decomposition:
- Shared package dbg_pkg holds:
  - typedef dbg_state_e {CAPTURE, FROZEN, DUMP}
  - typedef fetch_rec_t {pc, inst}, parametrised via package localparams PC_W_DEF=64, INST_W_DEF=32
- One sub-module is natural: dbg_trace_ring. It is a DEPTH x record register-file ring with write pointer, occupancy and read port, reusable by future trace blocks. The FSM, filter and stall logic stay in dbg_fetch_trace.

Test Plan:
- filter 0x8000_0000..0x8000_FFFF; 5 hits plus 3 out-of-range fetches -> occupancy=5, fetch_count=5.
- 20 hits with pc=0x8000_0000+4k, k=0..19, DEPTH=16; freeze; dump_req; dump_ready=1 -> 16 beats, pc 0x8000_0010..0x8000_004C; dump_last on beat 16; occupancy then 0.
- During dump, hold dump_ready=0 for 3 cycles on beat 2 -> dump_valid stays high and dump_pc stays stable; no beat lost or duplicated.
- fetch_valid=0 for 1024 cycles -> stall_alarm rises at cycle 1024; one fetch_valid clears it next cycle.
- Freeze with empty buffer then dump_req -> dump_valid never asserts; state stays FROZEN.
- Assert rst_n=0 mid-dump (beat 5 of 16) -> dump_valid=0 and occupancy=0 asynchronously; capture resumes after release.
